// File: rtl/manchester_2_nrz_decoder.sv
`timescale 1ns/1ps
// Manchester-to-NRZ receiver: acquires half-bit phase from the line, decodes one
// bit per two samples and packs WIDTH bits into word_out, first bit in the MSB.
module manchester_2_nrz_decoder #(
    parameter int WIDTH = 8
) (
    input  logic             clock_2x,
    input  logic             reset_b,
    input  logic             B_in,
    output logic             B_out,
    output logic             bit_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_valid,
    output logic             locked,
    output logic             code_err
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {HUNT, FIRST, SECOND} state_t;

    state_t           state_q, state_d;
    logic             sync1_q, sync1_d, s_q, s_d, h1_q, h1_d, h2_q, h2_d;
    logic [1:0]       hist_cnt_q, hist_cnt_d;
    logic             sync_q, sync_d, first_half_q, first_half_d;
    logic [WIDTH-2:0] shift_q, shift_d;
    logic [WIDTH-1:0] word_out_q, word_out_d, next_word;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             B_out_q, B_out_d, bit_valid_q, bit_valid_d;
    logic             word_valid_q, word_valid_d, locked_q, locked_d;
    logic             code_err_q, code_err_d;
    logic             lock_hit, pair_ok;

    // A held level following an edge marks the first half of a 1 after a 0 (preamble 0,1).
    assign lock_hit  = (hist_cnt_q == 2'd2) && (h2_q != h1_q) && (h1_q == s_q);
    assign pair_ok   = (s_q != first_half_q);
    assign next_word = {shift_q, first_half_q};

    always_ff @(posedge clock_2x or negedge reset_b) begin
        if (!reset_b) state_q <= HUNT;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            HUNT:    if (lock_hit) state_d = SECOND;
            FIRST:   state_d = SECOND;
            SECOND:  state_d = pair_ok ? FIRST : HUNT;
            default: state_d = HUNT;
        endcase
    end

    always_comb begin
        sync1_d      = B_in;
        s_d          = sync1_q;
        h1_d         = s_q;
        h2_d         = h1_q;
        hist_cnt_d   = (hist_cnt_q == 2'd2) ? hist_cnt_q : hist_cnt_q + 2'd1;
        sync_d       = sync_q;
        first_half_d = first_half_q;
        shift_d      = shift_q;
        word_out_d   = word_out_q;
        bit_cnt_d    = bit_cnt_q;
        B_out_d      = B_out_q;
        bit_valid_d  = 1'b0;
        word_valid_d = 1'b0;
        locked_d     = locked_q;
        code_err_d   = 1'b0;
        case (state_q)
            HUNT: begin
                if (lock_hit) begin
                    locked_d     = 1'b1;
                    sync_d       = 1'b1;
                    first_half_d = s_q;
                end
            end
            FIRST: first_half_d = s_q;
            SECOND: begin
                if (pair_ok) begin
                    // The sync bit only establishes phase; it never reaches the word.
                    if (sync_q) begin
                        sync_d = 1'b0;
                    end else begin
                        B_out_d     = first_half_q;
                        bit_valid_d = 1'b1;
                        shift_d     = next_word[WIDTH-2:0];
                        if (bit_cnt_q == CW'(WIDTH - 1)) begin
                            word_out_d   = next_word;
                            word_valid_d = 1'b1;
                            bit_cnt_d    = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CW'(1);
                        end
                    end
                end else begin
                    code_err_d = 1'b1;
                    locked_d   = 1'b0;
                    bit_cnt_d  = '0;
                    sync_d     = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock_2x or negedge reset_b) begin
        if (!reset_b) begin
            sync1_q      <= 1'b0;
            s_q          <= 1'b0;
            h1_q         <= 1'b0;
            h2_q         <= 1'b0;
            hist_cnt_q   <= 2'd0;
            sync_q       <= 1'b0;
            first_half_q <= 1'b0;
            shift_q      <= '0;
            word_out_q   <= '0;
            bit_cnt_q    <= '0;
            B_out_q      <= 1'b0;
            bit_valid_q  <= 1'b0;
            word_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            code_err_q   <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            s_q          <= s_d;
            h1_q         <= h1_d;
            h2_q         <= h2_d;
            hist_cnt_q   <= hist_cnt_d;
            sync_q       <= sync_d;
            first_half_q <= first_half_d;
            shift_q      <= shift_d;
            word_out_q   <= word_out_d;
            bit_cnt_q    <= bit_cnt_d;
            B_out_q      <= B_out_d;
            bit_valid_q  <= bit_valid_d;
            word_valid_q <= word_valid_d;
            locked_q     <= locked_d;
            code_err_q   <= code_err_d;
        end
    end

    assign B_out      = B_out_q;
    assign bit_valid  = bit_valid_q;
    assign word_out   = word_out_q;
    assign word_valid = word_valid_q;
    assign locked     = locked_q;
    assign code_err   = code_err_q;

endmodule

// File: tb/tb_manchester_2_nrz_decoder.sv
`timescale 1ns/1ps
// Directed bench for manchester_2_nrz_decoder: encoder-style line stimulus, a
// sample-stream reference model compared every cycle, and literal scenario checks.
module tb_manchester_2_nrz_decoder;
    localparam int WIDTH = 8;

    logic             clock_2x = 1'b0;
    logic             reset_b  = 1'b0;
    logic             B_in     = 1'b0;
    logic             B_out, bit_valid, word_valid, locked, code_err;
    logic [WIDTH-1:0] word_out;

    manchester_2_nrz_decoder #(.WIDTH(WIDTH)) dut (
        .clock_2x  (clock_2x),
        .reset_b   (reset_b),
        .B_in      (B_in),
        .B_out     (B_out),
        .bit_valid (bit_valid),
        .word_out  (word_out),
        .word_valid(word_valid),
        .locked    (locked),
        .code_err  (code_err)
    );

    always #5 clock_2x = ~clock_2x;

    int n_chk = 0, n_pass = 0;

    // Activity counters, only ever stepped by the compare process.
    int          cyc = 0, n_bv = 0, n_wv = 0, n_ce = 0, n_lk = 0;
    int          wv_t_prev = 0, wv_t_last = 0;
    logic [31:0] bit_hist = '0;
    logic [7:0]  w_prev = '0, w_last = '0;

    // Reference model over the raw line samples taken since reset release.
    int               raw_q[$];
    bit               mdl_locked = 1'b0;
    int               lock_m = 0, nbits = 0, shv = 0;
    bit               e_bout = 1'b0, e_bv = 1'b0, e_wv = 1'b0, e_ce = 1'b0;
    logic [WIDTH-1:0] e_word = '0;
    logic [WIDTH+4:0] exp_v, act_v;

    function automatic int rawat(input int k);
        return (k >= 1) ? raw_q[k-1] : 0;
    endfunction

    // Edge m judges the sample taken at edge m-2; once locked, odd offsets from
    // the lock edge close a half-bit pair, and the first pair is the sync bit.
    task automatic model_step(input logic line);
        int m, s, h1, h2, fh;
        m  = raw_q.size() + 1;
        s  = rawat(m - 2);
        h1 = rawat(m - 3);
        h2 = rawat(m - 4);
        e_bv = 1'b0; e_wv = 1'b0; e_ce = 1'b0;
        if (!mdl_locked) begin
            if (m >= 3 && h2 != h1 && h1 == s) begin
                mdl_locked = 1'b1;
                lock_m     = m;
            end
        end else if ((m - lock_m) % 2 == 1) begin
            fh = h1;
            if (fh == s) begin
                e_ce = 1'b1; mdl_locked = 1'b0; nbits = 0;
            end else if (m != lock_m + 1) begin
                e_bv   = 1'b1;
                e_bout = fh[0];
                shv    = ((shv << 1) | fh) & ((1 << WIDTH) - 1);
                nbits++;
                if (nbits == WIDTH) begin
                    e_word = shv[WIDTH-1:0]; e_wv = 1'b1; nbits = 0;
                end
            end
        end
        raw_q.push_back(int'(line));
    endtask

    initial begin
        forever begin
            @(posedge clock_2x or negedge reset_b);
            if (!reset_b) begin
                raw_q.delete();
                mdl_locked = 1'b0; nbits = 0; shv = 0;
                e_bout = 1'b0; e_bv = 1'b0; e_wv = 1'b0; e_ce = 1'b0; e_word = '0;
            end else begin
                model_step(B_in);
                #1;
                cyc++;
                exp_v = {e_bout, e_bv, e_word, e_wv, mdl_locked, e_ce};
                act_v = {B_out, bit_valid, word_out, word_valid, locked, code_err};
                n_chk++;
                if (act_v === exp_v) n_pass++;
                else $display("FAIL model cycle %0d: got %b expected %b (B_out,bv,word,wv,locked,err)",
                              cyc, act_v, exp_v);
                if (bit_valid) begin n_bv++; bit_hist = {bit_hist[30:0], B_out}; end
                if (word_valid) begin
                    n_wv++; wv_t_prev = wv_t_last; wv_t_last = cyc;
                    w_prev = w_last; w_last = word_out;
                end
                if (code_err) n_ce++;
                if (locked) n_lk++;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic half(input logic v);
        @(negedge clock_2x);
        B_in = v;
    endtask

    task automatic send_bit(input logic b);
        half(b);
        half(~b);
    endtask

    task automatic send_byte(input logic [7:0] x);
        for (int i = 7; i >= 0; i--) send_bit(x[i]);
    endtask

    task automatic preamble();
        send_bit(1'b0);
        send_bit(1'b1);
    endtask

    task automatic idle(input logic v, input int n);
        for (int i = 0; i < n; i++) half(v);
    endtask

    // Lets the last driven half-bit reach the outputs.
    task automatic settle();
        repeat (3) @(posedge clock_2x);
        #2;
    endtask

    int bv0, wv0, ce0, lk0;

    initial begin
        repeat (3) @(posedge clock_2x);
        #1;
        check("reset_state", 32'({B_out, bit_valid, word_out, word_valid, locked, code_err}), 32'h0);
        @(negedge clock_2x);
        reset_b = 1'b1;

        // Lock and decode 0xB2
        bv0 = n_bv; wv0 = n_wv; ce0 = n_ce;
        idle(1'b0, 6);
        preamble();
        send_byte(8'hB2);
        settle();
        check("t1_words", 32'(n_wv - wv0), 32'd1);
        check("t1_word_out", 32'(w_last), 32'hB2);
        check("t1_bits", 32'(n_bv - bv0), 32'd8);
        check("t1_bit_seq", 32'(bit_hist[7:0]), 32'hB2);
        check("t1_no_err", 32'(n_ce - ce0), 32'd0);
        check("t1_locked", 32'(locked), 32'd1);

        // Back-to-back words
        idle(1'b0, 8);
        settle();
        wv0 = n_wv; ce0 = n_ce;
        preamble();
        send_byte(8'hFF);
        send_byte(8'h00);
        settle();
        check("t2_words", 32'(n_wv - wv0), 32'd2);
        check("t2_first", 32'(w_prev), 32'hFF);
        check("t2_second", 32'(w_last), 32'h00);
        check("t2_spacing", 32'(wv_t_last - wv_t_prev), 32'd16);
        check("t2_no_err", 32'(n_ce - ce0), 32'd0);
        check("t2_locked", 32'(locked), 32'd1);

        // No lock on a constant line or on alternating samples
        bv0 = n_bv;
        idle(1'b1, 40);
        settle();
        check("t3_const_bits", 32'(n_bv - bv0), 32'd0);
        check("t3_const_unlocked", 32'(locked), 32'd0);
        bv0 = n_bv; lk0 = n_lk;
        for (int i = 0; i < 40; i++) half(logic'(i % 2));
        settle();
        check("t3_alt_bits", 32'(n_bv - bv0), 32'd0);
        check("t3_alt_lock_cycles", 32'(n_lk - lk0), 32'd0);

        // Violation then relock
        idle(1'b0, 8);
        settle();
        bv0 = n_bv; wv0 = n_wv; ce0 = n_ce;
        preamble();
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        half(1'b1); half(1'b1);
        settle();
        check("t4_err_pulse", 32'(code_err), 32'd1);
        check("t4_unlocked", 32'(locked), 32'd0);
        check("t4_bits_before", 32'(n_bv - bv0), 32'd3);
        preamble();
        send_byte(8'h5A);
        settle();
        check("t4_err_count", 32'(n_ce - ce0), 32'd1);
        check("t4_words", 32'(n_wv - wv0), 32'd1);
        check("t4_word_out", 32'(w_last), 32'h5A);
        check("t4_relocked", 32'(locked), 32'd1);

        // Reset mid-word
        idle(1'b0, 8);
        settle();
        preamble();
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        check("t5_locked_before", 32'(locked), 32'd1);
        @(posedge clock_2x);
        #3;
        reset_b = 1'b0;
        #0.5;
        check("t5_async_clear", 32'({B_out, bit_valid, word_out, word_valid, locked, code_err}), 32'h0);
        #0.5;
        reset_b = 1'b1;
        wv0 = n_wv;
        idle(1'b0, 6);
        preamble();
        send_byte(8'h3C);
        settle();
        check("t5_words", 32'(n_wv - wv0), 32'd1);
        check("t5_word_out", 32'(w_last), 32'h3C);

        // Idle high before the preamble
        wv0 = n_wv;
        idle(1'b1, 8);
        preamble();
        send_byte(8'hA5);
        settle();
        check("t6_words", 32'(n_wv - wv0), 32'd1);
        check("t6_word_out", 32'(w_last), 32'hA5);
        check("t6_locked", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
